fifo_rd_ctrl: RTL and testbench

Downstream drain stage for `fifo_mem`. It pops words from the FIFO read port and tolerates the FIFO's one-cycle read latency with a 2-entry output buffer. It presents the words in order on a valid/ready stream toward the consumer. It sustains one word per cycle when the FIFO is non-empty and the consumer is ready, and never reads an empty FIFO.

---
 rtl/fifo_rd_ctrl_if.sv | 12 +
 rtl/fifo_rd_ctrl.sv | 117 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// Valid/ready output stream of the FIFO drain stage.
// The master drives valid and data; the slave (consumer) drives ready.
interface fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Drain stage for fifo_mem: hides the one-cycle read latency behind a 2-entry
// buffer and presents the popped words in order on a valid/ready stream.
//
// state   | meaning
// --------+-------------------------------------------
// S_EMPTY | no word buffered, m_valid low
// S_ONE   | one word buffered in buf0
// S_TWO   | two words buffered, buf0 is the head
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_in,
    input  logic                  areset_b,
    input  logic                  rd_enable,
    input  logic                  fifo_empty_ind,
    input  logic                  fifo_underflow_ind,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_trans_read,
    fifo_rd_ctrl_if.master        m_if,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  underflow_err
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    logic [DATA_WIDTH-1:0] buf0_nxt;
    logic [DATA_WIDTH-1:0] buf1_nxt;
    logic [1:0]            occ;
    logic [1:0]            credit;
    logic                  m_valid;
    logic                  pop;

    assign occ         = state;
    assign m_valid     = (state != S_EMPTY);
    assign m_if.m_valid = m_valid;
    assign m_if.m_data = buf0;
    assign pop         = m_valid & m_if.m_ready;
    assign credit      = occ + {1'b0, inflight};

    // A read is allowed only if its word is guaranteed a buffer slot on arrival.
    assign fifo_trans_read = areset_b & rd_enable & ~fifo_empty_ind &
                             ((credit < 2'd2) | ((credit == 2'd2) & pop));

    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            state    <= S_EMPTY;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_trans_read;
            buf0     <= buf0_nxt;
            buf1     <= buf1_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        buf0_nxt  = buf0;
        buf1_nxt  = buf1;
        case (state)
            S_EMPTY: begin
                if (inflight) begin
                    state_nxt = S_ONE;
                    buf0_nxt  = fifo_data_out;
                end
            end
            S_ONE: begin
                if (pop && inflight) begin
                    buf0_nxt = fifo_data_out;
                end else if (pop) begin
                    state_nxt = S_EMPTY;
                end else if (inflight) begin
                    state_nxt = S_TWO;
                    buf1_nxt  = fifo_data_out;
                end
            end
            S_TWO: begin
                // Without a pop the credit rule guarantees no capture is pending.
                if (pop) begin
                    buf0_nxt = buf1;
                    if (inflight) begin
                        buf1_nxt = fifo_data_out;
                    end else begin
                        state_nxt = S_ONE;
                    end
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            rd_count      <= '0;
            underflow_err <= 1'b0;
        end else begin
            rd_count      <= rd_count + CNT_WIDTH'(pop);
            underflow_err <= underflow_err | fifo_underflow_ind;
        end
    end

    a_credit_bound : assert property (@(posedge clk_in) disable iff (!areset_b)
        (3'(occ) + 3'(inflight)) <= 3'd2);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural FIFO model, scoreboard of pushed words,
// a per-cycle vector table for backpressure and hand sequences for corner cases.
module tb_fifo_rd_ctrl;
    localparam int DW = 16;
    localparam int CW = 16;

    logic          clk_in = 1'b0;
    logic          areset_b;
    logic          rd_enable;
    logic          fifo_empty_ind;
    logic          fifo_underflow_ind;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_trans_read;
    logic [CW-1:0] rd_count;
    logic          underflow_err;

    fifo_rd_ctrl_if #(.DATA_WIDTH(DW)) s_if ();

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_in             (clk_in),
        .areset_b           (areset_b),
        .rd_enable          (rd_enable),
        .fifo_empty_ind     (fifo_empty_ind),
        .fifo_underflow_ind (fifo_underflow_ind),
        .fifo_data_out      (fifo_data_out),
        .fifo_trans_read    (fifo_trans_read),
        .m_if               (s_if.master),
        .rd_count           (rd_count),
        .underflow_err      (underflow_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic          en;
        logic          rdy;
        logic          tr;
        logic          mv;
        logic [DW-1:0] md;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t          vecs[14];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mem_q[$];
    logic [DW-1:0] exp_q[$];
    int            issued;
    int            popped;
    logic [CW-1:0] cnt_model;
    logic          last_rd;
    logic          last_mv;
    logic [DW-1:0] last_md;
    logic [CW-1:0] last_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, then update the FIFO model just after the edge.
    task automatic cycle();
        logic          rd_s;
        logic          pop_s;
        logic [DW-1:0] dat_s;
        @(negedge clk_in);
        rd_s     = fifo_trans_read;
        pop_s    = s_if.m_valid & s_if.m_ready;
        dat_s    = s_if.m_data;
        last_rd  = rd_s;
        last_mv  = s_if.m_valid;
        last_md  = dat_s;
        last_cnt = rd_count;
        chk("no_read_when_empty", 32'(rd_s & fifo_empty_ind), 0);
        if (pop_s) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("sb_order", 32'(dat_s), 32'(exp_q.pop_front()));
        end
        @(posedge clk_in);
        #1;
        if (rd_s) begin
            if (mem_q.size() != 0) fifo_data_out = mem_q.pop_front();
            issued++;
        end
        if (pop_s) begin
            popped++;
            cnt_model++;
        end
        fifo_empty_ind = (mem_q.size() == 0);
        chk("rd_count", 32'(rd_count), 32'(cnt_model));
        chk("credit_le_2", 32'((issued - popped) <= 2), 1);
    endtask

    task automatic push_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            mem_q.push_back(DW'(first + i));
            exp_q.push_back(DW'(first + i));
        end
        fifo_empty_ind = (mem_q.size() == 0);
    endtask

    task automatic flush_fifo();
        mem_q.delete();
        exp_q.delete();
        fifo_empty_ind = 1'b1;
    endtask

    task automatic reset_dut();
        areset_b  = 1'b0;
        rd_enable = 1'b0;
        s_if.m_ready = 1'b0;
        @(posedge clk_in);
        #1;
        chk("rst_trans_read", 32'(fifo_trans_read), 0);
        chk("rst_m_valid", 32'(s_if.m_valid), 0);
        chk("rst_m_data", 32'(s_if.m_data), 0);
        chk("rst_rd_count", 32'(rd_count), 0);
        chk("rst_underflow", 32'(underflow_err), 0);
        issued    = 0;
        popped    = 0;
        cnt_model = '0;
        exp_q     = mem_q;
        areset_b  = 1'b1;
    endtask

    task automatic drain(input int n, input int budget);
        int target;
        int b;
        target = popped + n;
        b = 0;
        rd_enable = 1'b1;
        s_if.m_ready = 1'b1;
        while (popped < target && b < budget) begin
            cycle();
            b++;
        end
        chk("drain_timeout", 32'(popped >= target), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int b;
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h1, 16'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h1, 16'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h1, 16'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h1, 16'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h2, 16'd1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h3, 16'd2};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h4, 16'd3};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h5, 16'd4};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h6, 16'd5};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h7, 16'd6};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h8, 16'd7};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'd8};

        fifo_data_out      = '0;
        fifo_underflow_ind = 1'b0;
        issued             = 0;
        popped             = 0;
        cnt_model          = '0;
        flush_fifo();
        reset_dut();

        // Empty FIFO after release: no reads, no output.
        rd_enable    = 1'b1;
        s_if.m_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("idle_trans_read", 32'(last_rd), 0);
            chk("idle_m_valid", 32'(last_mv), 0);
        end

        // Backpressure fill then release, driven from the vector table.
        flush_fifo();
        reset_dut();
        push_words(1, 8);
        for (int i = 0; i < 14; i++) begin
            rd_enable    = vecs[i].en;
            s_if.m_ready = vecs[i].rdy;
            cycle();
            chk($sformatf("vec%0d_trans_read", i), 32'(last_rd), 32'(vecs[i].tr));
            chk($sformatf("vec%0d_m_valid", i), 32'(last_mv), 32'(vecs[i].mv));
            if (vecs[i].mv) chk($sformatf("vec%0d_m_data", i), 32'(last_md), 32'(vecs[i].md));
            chk($sformatf("vec%0d_rd_count", i), 32'(last_cnt), 32'(vecs[i].cnt));
        end

        // Streaming 17 words: 2-cycle latency then one word per cycle.
        flush_fifo();
        reset_dut();
        push_words(1, 17);
        rd_enable    = 1'b1;
        s_if.m_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (k == 0) chk("stream_first_read", 32'(last_rd), 1);
            chk($sformatf("stream_valid_k%0d", k), 32'(last_mv), 32'(k >= 2 && k <= 18));
        end
        chk("stream_rd_count", 32'(rd_count), 17);
        chk("stream_sb_drained", 32'(exp_q.size()), 0);

        // rd_enable dropped right after a read: that word still arrives, nothing more issued.
        flush_fifo();
        reset_dut();
        push_words(16'h40, 4);
        rd_enable    = 1'b1;
        s_if.m_ready = 1'b1;
        cycle();
        chk("en_drop_read0", 32'(last_rd), 1);
        rd_enable = 1'b0;
        for (int k = 1; k < 7; k++) begin
            cycle();
            chk($sformatf("en_drop_no_read_k%0d", k), 32'(last_rd), 0);
            chk($sformatf("en_drop_valid_k%0d", k), 32'(last_mv), 32'(k == 2));
            if (k == 2) chk("en_drop_word", 32'(last_md), 32'h40);
        end
        chk("en_drop_count", 32'(rd_count), 1);
        drain(3, 50);

        // Random writes and random consumer readiness.
        flush_fifo();
        reset_dut();
        rd_enable = 1'b1;
        w = 1;
        b = 0;
        while (popped < 1000 && b < 20000) begin
            if (w <= 1000 && $urandom_range(1, 0) == 1) begin
                push_words(w, 1);
                w++;
            end
            s_if.m_ready = 1'($urandom_range(1, 0));
            cycle();
            b++;
        end
        chk("rand_timeout", 32'(popped >= 1000), 1);
        chk("rand_underflow", 32'(underflow_err), 0);
        chk("rand_sb_drained", 32'(exp_q.size()), 0);

        // Reset mid-stream discards buffered and in-flight words.
        flush_fifo();
        reset_dut();
        push_words(1, 8);
        rd_enable    = 1'b1;
        s_if.m_ready = 1'b1;
        for (int k = 0; k < 5; k++) cycle();
        chk("mid_popped", 32'(popped), 3);
        areset_b = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(s_if.m_valid), 0);
        chk("mid_rst_count", 32'(rd_count), 0);
        chk("mid_rst_read", 32'(fifo_trans_read), 0);
        issued    = 0;
        popped    = 0;
        cnt_model = '0;
        exp_q     = mem_q;
        chk("mid_remaining", 32'(exp_q.size()), 3);
        cycle();
        areset_b = 1'b1;
        drain(3, 50);
        chk("mid_rd_count", 32'(rd_count), 3);

        // Sticky underflow error.
        fifo_underflow_ind = 1'b1;
        cycle();
        fifo_underflow_ind = 1'b0;
        chk("uflow_set", 32'(underflow_err), 1);
        for (int k = 0; k < 3; k++) cycle();
        chk("uflow_sticky", 32'(underflow_err), 1);
        flush_fifo();
        reset_dut();
        cycle();
        chk("uflow_cleared", 32'(underflow_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
